cr_drain_pack: RTL

//  Drain stage behind the credit pipeline's 16-bit output FIFO (fifo_32x16fw, first-word-fall-through).

---
 rtl/cr_pkg.sv | 19 +
 rtl/cr_skid2.sv | 86 ++++++++
 rtl/cr_drain_pack.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cr_pkg.sv
// Shared types and widths for the credit-pipeline drain stage.
package cr_pkg;

  localparam int CR_WORD_W   = 16;
  localparam int CR_BEAT_W   = 32;
  localparam int CR_PKTCNT_W = 16;

  typedef enum logic {
    S_LO = 1'b0,
    S_HI = 1'b1
  } drain_state_t;

  // Output beat layout: high word in the upper half.
  function automatic logic [CR_BEAT_W-1:0] cr_pack(input logic [CR_WORD_W-1:0] hi,
                                                   input logic [CR_WORD_W-1:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/cr_skid2.sv
// Two-entry output buffer with registered valid/data/last.
// Entry 0 is the head and drives the stream outputs directly.
module cr_skid2
  import cr_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push,
  input  logic [CR_BEAT_W-1:0] push_data,
  input  logic                 push_last,
  output logic [CR_BEAT_W-1:0] m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic [1:0]           count
);

  logic [CR_BEAT_W-1:0] e0_data, e1_data, e0_data_nxt, e1_data_nxt;
  logic                 e0_last, e1_last, e0_last_nxt, e1_last_nxt;
  logic [1:0]           count_nxt;
  logic                 pop;

  assign pop     = m_tvalid & m_tready;
  assign m_tdata = e0_data;
  assign m_tlast = e0_last;

  // Next buffer contents: push and pop may both happen in one cycle.
  always_comb begin
    count_nxt   = count;
    e0_data_nxt = e0_data;
    e0_last_nxt = e0_last;
    e1_data_nxt = e1_data;
    e1_last_nxt = e1_last;
    case ({push, pop})
      2'b10: begin
        if (count == 2'd0) begin
          e0_data_nxt = push_data;
          e0_last_nxt = push_last;
        end else begin
          e1_data_nxt = push_data;
          e1_last_nxt = push_last;
        end
        count_nxt = count + 2'd1;
      end
      2'b01: begin
        if (count == 2'd2) begin
          e0_data_nxt = e1_data;
          e0_last_nxt = e1_last;
        end
        count_nxt = count - 2'd1;
      end
      2'b11: begin
        if (count == 2'd2) begin
          e0_data_nxt = e1_data;
          e0_last_nxt = e1_last;
          e1_data_nxt = push_data;
          e1_last_nxt = push_last;
        end else begin
          e0_data_nxt = push_data;
          e0_last_nxt = push_last;
        end
      end
      default: ;
    endcase
  end

  // Buffer registers; valid is its own flop so the output is glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= 2'd0;
      m_tvalid <= 1'b0;
      e0_data  <= '0;
      e0_last  <= 1'b0;
      e1_data  <= '0;
      e1_last  <= 1'b0;
    end else begin
      count    <= count_nxt;
      m_tvalid <= (count_nxt != 2'd0);
      e0_data  <= e0_data_nxt;
      e0_last  <= e0_last_nxt;
      e1_data  <= e1_data_nxt;
      e1_last  <= e1_last_nxt;
    end
  end

endmodule

// File: rtl/cr_drain_pack.sv
// Drain stage: pops 16-bit words from an FWFT FIFO, packs pairs into
// 32-bit beats, marks tlast every PKT_BEATS beats, and counts packets.
//
//   state | meaning
//   S_LO  | waiting for the low word of the next beat
//   S_HI  | low word held in lo_reg; waiting for the high word or a flush
module cr_drain_pack
  import cr_pkg::*;
#(
  parameter int PKT_BEATS = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [CR_WORD_W-1:0]   fifo_dout,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic                   flush,
  output logic [CR_BEAT_W-1:0]   m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic                   pkt_done,
  output logic [CR_PKTCNT_W-1:0] pkt_count
);

  localparam logic [7:0] LAST_IDX = 8'(PKT_BEATS - 1);

  drain_state_t         state, state_nxt;
  logic [CR_WORD_W-1:0] lo_reg;
  logic [7:0]           beat_cnt;
  logic                 flush_pend;
  logic                 flush_req;
  logic                 pop_word;
  logic                 push;
  logic [CR_BEAT_W-1:0] push_data;
  logic                 push_last;
  logic [1:0]           skid_count;
  logic [1:0]           occ_after;
  logic                 space;
  logic                 beat_last;
  logic                 acc_last;

  // Occupancy left once this cycle's accepted beat has gone.
  assign occ_after = skid_count - 2'(m_tvalid & m_tready);
  assign space     = (occ_after < 2'd2);
  assign beat_last = (beat_cnt == LAST_IDX);
  // A flush that met a full buffer is held until there is room for it.
  assign flush_req = flush | flush_pend;
  // Pop is masked during reset so no word is consumed while held in reset.
  assign fifo_rd_en = pop_word & reset_n;
  assign acc_last   = m_tvalid & m_tready & m_tlast;

  // Next-state, pop and push decisions.
  always_comb begin
    state_nxt = state;
    pop_word  = 1'b0;
    push      = 1'b0;
    push_data = cr_pack(fifo_dout, lo_reg);
    push_last = 1'b0;
    case (state)
      S_LO: begin
        if (!fifo_empty && space) begin
          pop_word  = 1'b1;
          state_nxt = S_HI;
        end
      end
      S_HI: begin
        if (flush_req) begin
          if (space) begin
            push      = 1'b1;
            push_data = cr_pack('0, lo_reg);
            push_last = 1'b1;
            state_nxt = S_LO;
          end
        end else if (!fifo_empty && space) begin
          pop_word  = 1'b1;
          push      = 1'b1;
          push_last = beat_last;
          state_nxt = S_LO;
        end
      end
      default: state_nxt = S_LO;
    endcase
  end

  // FSM state, low-word holding register, beat position and pending flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_LO;
      lo_reg     <= '0;
      beat_cnt   <= 8'd0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_pend <= (state == S_HI) && flush_req && !space;
      if (pop_word && state == S_LO)
        lo_reg <= fifo_dout;
      if (push)
        beat_cnt <= push_last ? 8'd0 : beat_cnt + 8'd1;
    end
  end

  // Packet completion pulse and running count of accepted packets.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_done  <= 1'b0;
      pkt_count <= '0;
    end else begin
      pkt_done  <= acc_last;
      pkt_count <= pkt_count + CR_PKTCNT_W'(acc_last);
    end
  end

  cr_skid2 u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .push_last (push_last),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast),
    .count     (skid_count)
  );

endmodule
